rsa_modexp_core: RTL and testbench

- Parametrised RSA modular-exponentiation engine: computes c = M^e mod n for WIDTH-bit operands.
- Successor to the register-only encrypt wrapper. Adds an actual square-and-multiply datapath, a bit-serial interleaved modular multiplier, a valid/ready handshake on both sides, and operand range checking.
- Sits between the OS2IP and I2OSP conversion stages; used for both RSA encryption and verification.

---
 rtl/rsa_modexp_core.sv | 227 ++++++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
//   RSA modular-exponentiation engine: c = M^e mod n for WIDTH-bit operands.
//   Left-to-right square-and-multiply over a bit-serial interleaved modular
//   multiplier (MSB first, one multiplier bit per clock).
//
// Build option:
//   RSA_CONST_TIME_EN - when defined, leading-zero skipping is removed and a
//                       multiply is issued for every exponent bit, with its
//                       product discarded when the bit is 0. Latency then
//                       depends only on WIDTH.
//
// Parameters:
//   WIDTH  operand width (8..4096)
//   CNT_W  bit-index counter width, derived from WIDTH; do not override
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   e, n and M are valid
//   in_ready   operands can be accepted (IDLE only)
//   e, n, M    exponent, modulus, message (M < n required)
//   out_valid  c and err are valid; held until out_ready
//   out_ready  downstream accepts the result
//   c          M^e mod n, 0 when err=1
//   err        operand error: n < 2 or M >= n
//   busy       high in every state except IDLE
module rsa_modexp_core #(
  parameter int WIDTH = 2048,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             err,
  output logic             busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] SKIP  = 3'd2;
  localparam logic [2:0] SQR   = 3'd3;
  localparam logic [2:0] MUL   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(WIDTH - 1);

  // One step of the interleaved multiplier. r_in < m and b < m on entry, so
  // the doubled value is < 2m and the sum after the first fold is < 2m:
  // a single conditional subtract after each keeps the result below m.
  function automatic logic [WIDTH+1:0] mm_step(
    input logic [WIDTH+1:0] r_in,
    input logic             a_bit,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] mod;
    mod = {2'b00, m};
    t   = r_in << 1;
    if (t >= mod) t = t - mod;
    if (a_bit)    t = t + {2'b00, b};
    if (t >= mod) t = t - mod;
    return t;
  endfunction

  logic [2:0]       state;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH+1:0] r;
  logic [CNT_W-1:0] i;
  logic [CNT_W-1:0] j;
  logic [WIDTH-1:0] c_q;
  logic             err_q;

  logic             a_bit;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH+1:0] r_next;
  logic [WIDTH-1:0] mul_acc;
  logic [CNT_W-1:0] im1;
  logic             e_bit;
  logic             e_nxt_bit;
  logic             mul_last;
  logic             op_bad;

  always_comb begin
    a_bit     = acc[j[CNT_W-2:0]];
    mul_b     = (state == SQR) ? acc : m_q;
    r_next    = mm_step(r, a_bit, mul_b, n_q);
    im1       = i - CNT_W'(1);
    e_bit     = e_q[i[CNT_W-2:0]];
    e_nxt_bit = e_q[im1[CNT_W-2:0]];
    mul_last  = (j == '0);
    op_bad    = (n_q < WIDTH'(2)) || (m_q >= n_q);
`ifdef RSA_CONST_TIME_EN
    // Dummy multiply for a 0 exponent bit: result computed, then dropped.
    mul_acc   = e_bit ? r_next[WIDTH-1:0] : acc;
`else
    mul_acc   = r_next[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      e_q   <= '0;
      n_q   <= '0;
      m_q   <= '0;
      acc   <= '0;
      r     <= '0;
      i     <= '0;
      j     <= '0;
      c_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            e_q   <= e;
            n_q   <= n;
            m_q   <= M;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (op_bad) begin
            err_q <= 1'b1;
            c_q   <= '0;
            state <= DONE;
          end else begin
            err_q <= 1'b0;
            acc   <= WIDTH'(1);
            r     <= '0;
            i     <= TOP_IDX;
            j     <= TOP_IDX;
`ifdef RSA_CONST_TIME_EN
            state <= SQR;
`else
            // Top bit set: no zeros to skip, start squaring immediately.
            state <= e_q[WIDTH-1] ? SQR : SKIP;
`endif
          end
        end

        // Bit i is known to be 0; look one bit ahead so the first 1 enters
        // SQR without an extra cycle.
        SKIP: begin
          if (i == '0) begin
            c_q   <= WIDTH'(1);
            state <= DONE;
          end else begin
            i <= im1;
            if (e_nxt_bit) begin
              r     <= '0;
              j     <= TOP_IDX;
              state <= SQR;
            end
          end
        end

        SQR: begin
          if (!mul_last) begin
            r <= r_next;
            j <= j - CNT_W'(1);
          end else begin
            acc <= r_next[WIDTH-1:0];
            r   <= '0;
            j   <= TOP_IDX;
`ifdef RSA_CONST_TIME_EN
            state <= MUL;
`else
            if (e_bit) begin
              state <= MUL;
            end else if (i == '0) begin
              c_q   <= r_next[WIDTH-1:0];
              state <= DONE;
            end else begin
              i     <= im1;
              state <= SQR;
            end
`endif
          end
        end

        MUL: begin
          if (!mul_last) begin
            r <= r_next;
            j <= j - CNT_W'(1);
          end else begin
            acc <= mul_acc;
            r   <= '0;
            j   <= TOP_IDX;
            if (i == '0) begin
              c_q   <= mul_acc;
              state <= DONE;
            end else begin
              i     <= im1;
              state <= SQR;
            end
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign c         = c_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
module tb_rsa_modexp_core;

  localparam int SW = 16;
  localparam int BW = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // small instance
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [SW-1:0] s_e = '0, s_n = '0, s_m = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic [SW-1:0] s_c;
  logic          s_err;
  logic          s_busy;

  rsa_modexp_core #(.WIDTH(SW)) u_small (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .e(s_e), .n(s_n), .M(s_m),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .c(s_c), .err(s_err), .busy(s_busy)
  );

  // large instance
  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [BW-1:0] b_e = '0, b_n = '0, b_m = '0;
  logic          b_out_valid;
  logic          b_out_ready = 1'b0;
  logic [BW-1:0] b_c;
  logic          b_err;
  logic          b_busy;

  rsa_modexp_core #(.WIDTH(BW)) u_big (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .e(b_e), .n(b_n), .M(b_m),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .c(b_c), .err(b_err), .busy(b_busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [SW-1:0] ref_pow(input logic [SW-1:0] ex, input logic [SW-1:0] md,
                                            input logic [SW-1:0] base);
    longint r;
    r = 1;
    for (int k = 0; k < int'(ex); k++) r = (r * longint'(base)) % longint'(md);
    return SW'(r);
  endfunction

  function automatic int ref_lat(input logic [SW-1:0] ex, input bit bad);
    int z;
    int b;
    if (bad) return 2;
`ifdef RSA_CONST_TIME_EN
    return 2 + 2 * SW * SW;
`else
    z = SW;
    for (int k = SW - 1; k >= 0; k--) if (ex[k]) begin z = SW - 1 - k; break; end
    b = SW - z;
    return 1 + z + SW * (b + $countones(ex)) + 1;
`endif
  endfunction

  function automatic logic [BW-1:0] big_pow(input logic [BW-1:0] base, input logic [BW-1:0] ex,
                                            input logic [BW-1:0] md);
    logic [2*BW-1:0] r, b, m;
    logic [BW-1:0]   es;
    r  = 1;
    b  = {{BW{1'b0}}, base};
    m  = {{BW{1'b0}}, md};
    es = ex;
    while (es != '0) begin
      if (es[0]) r = (r * b) % m;
      b  = (b * b) % m;
      es = es >> 1;
    end
    return r[BW-1:0];
  endfunction

  // ---------------- small-instance helpers ----------------
  task automatic handoff_small(input string tag);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk({tag, "_ov_after"}, 64'(s_out_valid), 64'd0);
    chk({tag, "_rdy_after"}, 64'(s_in_ready), 64'd1);
  endtask

  task automatic start_small(input logic [SW-1:0] ex, input logic [SW-1:0] md,
                             input logic [SW-1:0] base);
    s_e = ex; s_n = md; s_m = base;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_e = SW'($urandom); s_n = SW'($urandom); s_m = SW'($urandom);
  endtask

  task automatic wait_small(output logic [SW-1:0] rc, output logic rerr, output int lat);
    lat = 1;
    while (!s_out_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!s_out_valid) begin
      checks++; fails++;
      $display("FAIL small_timeout: got no out_valid, expected one within 3000 cycles");
    end
    rc = s_c; rerr = s_err;
  endtask

  task automatic run_small(input string tag, input logic [SW-1:0] ex, input logic [SW-1:0] md,
                           input logic [SW-1:0] base, input logic [SW-1:0] ec,
                           input logic eerr, input int elat);
    logic [SW-1:0] rc;
    logic          rerr;
    int            lat;
    chk({tag, "_rdy_before"}, 64'(s_in_ready), 64'd1);
    start_small(ex, md, base);
    wait_small(rc, rerr, lat);
    chk({tag, "_c"},   64'(rc),   64'(ec));
    chk({tag, "_err"}, 64'(rerr), 64'(eerr));
    chk({tag, "_lat"}, 64'(lat),  64'(elat));
    handoff_small(tag);
  endtask

  typedef struct {
    logic [SW-1:0] e;
    logic [SW-1:0] n;
    logic [SW-1:0] m;
    logic [SW-1:0] c;
    logic          err;
    int            lat;
  } vec_t;

  vec_t tbl[10];

  initial begin : main
    logic [SW-1:0] rc;
    logic          rerr;
    int            lat;
    logic [SW-1:0] re, rn, rm, ec;
    bit            bad;
    int            elat;

    tbl[0] = '{e:16'd17, n:16'd3233, m:16'd65,   c:16'd2790, err:1'b0, lat:125};
    tbl[1] = '{e:16'd13, n:16'd497,  m:16'd4,    c:16'd445,  err:1'b0, lat:126};
    tbl[2] = '{e:16'd0,  n:16'd3233, m:16'd65,   c:16'd1,    err:1'b0, lat:18};
    tbl[3] = '{e:16'd17, n:16'd3233, m:16'd3233, c:16'd0,    err:1'b1, lat:2};
    tbl[4] = '{e:16'd17, n:16'd1,    m:16'd0,    c:16'd0,    err:1'b1, lat:2};
    tbl[5] = '{e:16'd5,  n:16'd2,    m:16'd1,    c:16'd1,    err:1'b0, lat:95};
    tbl[6] = '{e:16'd1,  n:16'd11,   m:16'd7,    c:16'd7,    err:1'b0, lat:49};
    tbl[7] = '{e:16'd3,  n:16'd5,    m:16'd0,    c:16'd0,    err:1'b0, lat:80};
    tbl[8] = '{e:16'd2,  n:16'd3233, m:16'd3232, c:16'd1,    err:1'b0, lat:64};
    tbl[9] = '{e:16'd7,  n:16'd0,    m:16'd0,    c:16'd0,    err:1'b1, lat:2};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(s_in_ready), 64'd1);
    chk("rst_out_valid", 64'(s_out_valid), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_err", 64'(s_err), 64'd0);
    chk("rst_c", 64'(s_c), 64'd0);

    // table vectors
    for (int k = 0; k < 10; k++) begin
`ifdef RSA_CONST_TIME_EN
      elat = tbl[k].err ? 2 : 2 + 2 * SW * SW;
`else
      elat = tbl[k].lat;
`endif
      run_small($sformatf("tbl%0d", k), tbl[k].e, tbl[k].n, tbl[k].m, tbl[k].c, tbl[k].err, elat);
    end

    // random vectors against the model
    for (int k = 0; k < 10; k++) begin
      re = SW'($urandom);
      rn = SW'($urandom_range(2, 65535));
      if (k % 4 == 3) rm = rn + SW'($urandom_range(0, 65535 - int'(rn)));
      else            rm = SW'($urandom % int'(rn));
      bad  = (rn < 2) || (rm >= rn);
      ec   = bad ? '0 : ref_pow(re, rn, rm);
      elat = ref_lat(re, bad);
      run_small($sformatf("rnd%0d", k), re, rn, rm, ec, bad, elat);
    end

    // backpressure: result held while out_ready stays low
    start_small(16'd13, 16'd497, 16'd4);
    wait_small(rc, rerr, lat);
    chk("bp_c0", 64'(rc), 64'd445);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("bp_ov",  64'(s_out_valid), 64'd1);
      chk("bp_c",   64'(s_c),         64'd445);
      chk("bp_err", 64'(s_err),       64'd0);
      chk("bp_rdy", 64'(s_in_ready),  64'd0);
    end
    handoff_small("bp");

    // reset during SQR of a new operation
    start_small(16'd17, 16'd3233, 16'd65);
    repeat (20) @(posedge clk);
    #3;
    chk("mid_busy_pre", 64'(s_busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy",  64'(s_in_ready),  64'd1);
    chk("mid_rst_ov",   64'(s_out_valid), 64'd0);
    chk("mid_rst_busy", 64'(s_busy),      64'd0);
    chk("mid_rst_err",  64'(s_err),       64'd0);
    chk("mid_rst_c",    64'(s_c),         64'd0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
`ifdef RSA_CONST_TIME_EN
    run_small("post_rst", 16'd17, 16'd3233, 16'd65, 16'd2790, 1'b0, 2 + 2 * SW * SW);
`else
    run_small("post_rst", 16'd17, 16'd3233, 16'd65, 16'd2790, 1'b0, 125);
`endif

`ifndef RSA_CONST_TIME_EN
    begin : big_test
      logic [BW-1:0] bn, bm, bexp;
      int            blat;
      int            belat;
      for (int w = 0; w < BW / 32; w++) begin
        bn[w*32 +: 32] = $urandom;
        bm[w*32 +: 32] = $urandom;
      end
      bn[BW-1] = 1'b1;
      bn[0]    = 1'b1;
      bm       = bm % bn;
      bexp     = big_pow(bm, BW'(65537), bn);
      belat    = 1 + (BW - 17) + BW * (17 + 2) + 1;

      chk("big_rdy_before", 64'(b_in_ready), 64'd1);
      b_e = BW'(65537); b_n = bn; b_m = bm;
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_e = BW'(3); b_m = bn;
      blat = 1;
      while (!b_out_valid && blat < 50000) begin
        if (blat == 100 || blat == 30000) begin
          b_in_valid = 1'b1;
          chk("big_rdy_busy", 64'(b_in_ready), 64'd0);
        end else begin
          b_in_valid = 1'b0;
        end
        @(posedge clk); #1;
        blat++;
      end
      b_in_valid = 1'b0;
      if (!b_out_valid) begin
        checks++; fails++;
        $display("FAIL big_timeout: got no out_valid, expected one within 50000 cycles");
      end
      checks++;
      if (b_c !== bexp) begin
        fails++;
        $display("FAIL big_c: got low64 %0h, expected low64 %0h", b_c[63:0], bexp[63:0]);
      end
      chk("big_err", 64'(b_err), 64'd0);
      chk("big_lat", 64'(blat), 64'(belat));
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("big_no_queue_ov", 64'(b_out_valid), 64'd0);
      chk("big_no_queue_busy", 64'(b_busy), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
